// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producer side, the write-port arbiter and the FIFO write port.
// The slave modport is the arbiter's view; master is the producers'/FIFO's view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                          arb_en;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_wr_en;
    logic                          fifo_full;

    modport slave (
        input  arb_en, req_din, req_valid, fifo_full,
        output req_ready, grant, grant_id, busy, fifo_din, fifo_wr_en
    );

    modport master (
        output arb_en, req_din, req_valid, fifo_full,
        input  req_ready, grant, grant_id, busy, fifo_din, fifo_wr_en
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// granting bursts of up to BURST_MAX words with one idle bubble between grants.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_wr_arbiter_if.slave       bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [GW-1:0]        gid_q, gid_d;
    logic [GW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 pick_found_s;
    logic [GW-1:0]        pick_id_s;
    logic                 busy_s;
    logic                 gvalid_s;
    logic                 xfer_s;
    logic [NUM_REQ-1:0]   ready_s;

    assign busy_s   = (state_q == S_GRANT);
    assign gvalid_s = bus.req_valid[gid_q];
    assign xfer_s   = busy_s & gvalid_s & ~bus.fifo_full;

    // Round-robin search starting just after the most recently granted requester.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx_v;
            idx_v = (int'(last_q) + k) % NUM_REQ;
            if (!pick_found_s && bus.req_valid[idx_v]) begin
                pick_found_s = 1'b1;
                pick_id_s    = GW'(idx_v);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        ready_s = '0;
        if (busy_s) begin
            ready_s[gid_q] = ~bus.fifo_full;
        end else begin
            ready_s = '0;
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting and release in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.arb_en && pick_found_s) begin
                    state_d = S_GRANT;
                    grant_d = NUM_REQ'(1) << pick_id_s;
                    gid_d   = pick_id_s;
                    last_d  = pick_id_s;
                    cnt_d   = CW'(0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // A dropped valid releases even when the FIFO is full; a full FIFO alone just holds.
                if (xfer_s && (cnt_q == CW'(BURST_MAX - 1))) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    cnt_d   = CW'(0);
                end else if (xfer_s) begin
                    cnt_d   = cnt_q + CW'(1);
                end else if (!gvalid_s) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    cnt_d   = CW'(0);
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                cnt_d   = CW'(0);
            end
        endcase
    end

    // State register; last starts at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gid_q   <= GW'(0);
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= CW'(0);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = busy_s;
    assign bus.fifo_din   = bus.req_din[gid_q*DATA_WIDTH +: DATA_WIDTH];
    assign bus.fifo_wr_en = xfer_s;
    assign bus.req_ready  = ready_s;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO (sync or async instance, write clock domain) among NUM_REQ requesters. Each requester presents a valid/ready word stream. The arbiter grants one requester at a time for bursts of up to BURST_MAX words. It drives the FIFO's din/wr_en directly and stalls on full. It sits in the FIFO's write clock domain, between the producers and the FIFO.

## Interface
- NUM_REQ, 4: number of requesters; ≥2.
- DATA_WIDTH, 8: word width; must equal the FIFO's DATA_WIDTH.
- BURST_MAX, 4: maximum words per grant; ≥1.
- clk  in  1  clock; the FIFO's wr_clk.
- rst  in  1  reset, asynchronous, active-high; the FIFO's wr_rst.
- arb_en  in  1  1 = new grants allowed; 0 = no new grant, current burst runs to completion.
- req_din  in  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_REQ  requester i has a word.
- req_ready  out  NUM_REQ  word of requester i accepted this cycle.
- grant  out  NUM_REQ  registered one-hot grant; all zero when idle.
- grant_id  out  GW = max(1, clog2(NUM_REQ))  index of the granted requester; holds its last value when idle.
- busy  out  1  state == GRANT.
- fifo_din  out  DATA_WIDTH  to FIFO din.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_full  in  1  from FIFO full.

## Operation
- State machine with two states, IDLE and GRANT. Round-robin pointer `last` (GW bits). Beat counter `cnt` (clog2(BURST_MAX+1) bits).
- IDLE transition:
  - If arb_en=1 and any req_valid=1, pick the first i with req_valid[i]=1, searching last+1, last+2, … modulo NUM_REQ.
  - Next edge: grant ← onehot(i), grant_id ← i, last ← i, cnt ← 0, state ← GRANT.
  - Otherwise stay in IDLE.
- Transfer in GRANT, where g = grant_id:
  - xfer = req_valid[g] & ~fifo_full.
  - fifo_wr_en = xfer.
  - fifo_din = req_din slice g, driven whenever busy; don't-care otherwise.
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
- All of fifo_wr_en, fifo_din and req_ready are combinational from the registered grant, req_valid and fifo_full. There are no registered data paths.
- Beat count: on xfer, cnt ← cnt+1.
- Release from GRANT to IDLE happens at the edge where either condition holds:
  - xfer and cnt == BURST_MAX-1 (burst complete), or
  - req_valid[g] == 0 (requester dropped valid). This releases even while fifo_full=1.
- On release: grant ← 0, cnt ← 0. last keeps g, so g gets lowest priority at the next arbitration.
- fifo_full=1 with req_valid[g]=1: hold the grant, no transfer, cnt unchanged. There is no timeout.
- arb_en=0 has no effect in GRANT. It only blocks the IDLE→GRANT transition.
- In IDLE: fifo_wr_en=0 and req_ready all zero.
- Reset (async, any state including mid-burst):
  - state=IDLE, grant=0, grant_id=0, last=NUM_REQ-1 (so requester 0 has first priority), cnt=0.
  - Outputs: busy=0, fifo_wr_en=0, req_ready=0. These drop immediately since they derive from state.
  - A word presented in the reset cycle is not written.
- Requester-side rule: req_din must stay stable while req_valid=1 and req_ready=0. The arbiter does not check this.

## Timing
- Grant latency: req_valid rising in IDLE gives grant on the next edge. The first fifo_wr_en can occur in the cycle after that edge.
- Each grant is followed by exactly one IDLE bubble cycle.
  - Sustained throughput with all requesters streaming and no full: BURST_MAX words per BURST_MAX+1 cycles.
- Write acceptance is zero-latency. A word is in the FIFO at the same edge where fifo_wr_en=1, consistent with the FIFO's full being combinational and current.
- Word order within one requester is preserved. Interleaving between requesters is at burst granularity only.

## Test plan
- Reset and idle, NUM_REQ=4, BURST_MAX=4, arb_en=1, single requester: after reset, req_valid=0001 held with fifo_full=0 → grant=0001 one edge later; 4 consecutive fifo_wr_en pulses carrying requester 0's words; grant=0 for 1 cycle; grant=0001 again.
- Round-robin: req_valid=1111 continuously, all words distinct → grant sequence 0,1,2,3,0…; each burst is 4 words; every 5th cycle is a bubble; FIFO contents are in that order.
- Full stall: in GRANT after 2 beats, assert fifo_full for 3 cycles → fifo_wr_en=0 and req_ready=0 for those cycles, cnt stays 2; after release exactly 2 more words are written, then grant=0.
- Early release: requester 2 granted, drops req_valid after 1 word → grant=0 at the next edge; next grant goes to the first valid requester after 2 (e.g. valid=1001 → requester 3).
- arb_en: clear arb_en mid-burst → burst completes to 4 words, then grant stays 0 while arb_en=0 even with req_valid=1111; arb_en=1 → grant resumes at the next requester in order.
- Async reset mid-burst (cnt=2, requester 1): assert rst between edges → fifo_wr_en, req_ready and busy go 0 immediately; after release, requester 0 wins arbitration with valid=0011.
